// File: rtl/mem_resp_demux.sv
// mem_resp_demux: registered 1-to-2 response demultiplexer for the shared
// main-memory return path. Each request granted to memory records its source
// (0 = I-cache, 1 = D-cache) in an in-order 1-bit tag FIFO. Each memory
// response pops the oldest tag and is steered, one cycle later, to the
// matching cache port.
//
// Optional feature: define MEM_RESP_DEMUX_ERR_EN to build a sticky ERR flag
// that records a response arriving with no outstanding request. Without the
// macro ERR is tied low and such responses are dropped silently.
module mem_resp_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         REQ_VALID,
  input  logic                         REQ_SRC,
  output logic                         REQ_READY,
  input  logic                         MEM_RESP_VALID,
  input  logic [DATA_WIDTH-1:0]        MEM_RESP_DATA,
  output logic                         OUT0_VALID,
  output logic [DATA_WIDTH-1:0]        OUT0_DATA,
  output logic                         OUT1_VALID,
  output logic [DATA_WIDTH-1:0]        OUT1_DATA,
  output logic [$clog2(DEPTH+1)-1:0]   PENDING,
  output logic                         ERR
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DEPTH-1:0]      tags_q, tags_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  out0_valid_q, out0_valid_d;
  logic                  out1_valid_q, out1_valid_d;
  logic [DATA_WIDTH-1:0] out0_data_q, out0_data_d;
  logic [DATA_WIDTH-1:0] out1_data_q, out1_data_d;

  logic push;
  logic pop;
  logic head_tag;

  // Ready depends only on the registered count, so a full FIFO blocks a
  // push even when a pop happens in the same cycle (no full-bypass).
  assign REQ_READY = (count_q != FULL_COUNT);
  assign push      = REQ_VALID && REQ_READY;
  assign pop       = MEM_RESP_VALID && (count_q != '0);
  assign head_tag  = tags_q[rd_ptr_q];

  // Next-state for the tag FIFO and the steered, registered outputs.
  always_comb begin
    tags_d       = tags_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out0_valid_d = 1'b0;
    out1_valid_d = 1'b0;
    out0_data_d  = out0_data_q;
    out1_data_d  = out1_data_q;

    if (push) begin
      tags_d[wr_ptr_q] = REQ_SRC;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (head_tag) begin
        out1_valid_d = 1'b1;
        out1_data_d  = MEM_RESP_DATA;
      end else begin
        out0_valid_d = 1'b1;
        out0_data_d  = MEM_RESP_DATA;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every outstanding tag immediately.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tags_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
      out0_data_q  <= '0;
      out1_data_q  <= '0;
    end else begin
      tags_q       <= tags_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out0_valid_q <= out0_valid_d;
      out1_valid_q <= out1_valid_d;
      out0_data_q  <= out0_data_d;
      out1_data_q  <= out1_data_d;
    end
  end

  assign OUT0_VALID = out0_valid_q;
  assign OUT0_DATA  = out0_data_q;
  assign OUT1_VALID = out1_valid_q;
  assign OUT1_DATA  = out1_data_q;
  assign PENDING    = count_q;

`ifdef MEM_RESP_DEMUX_ERR_EN
  logic err_q, err_d;

  // Sticky flag: any response seen while nothing is outstanding.
  always_comb begin
    err_d = err_q | (MEM_RESP_VALID && (count_q == '0));
  end

  // Error register, cleared only by reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mem_resp_demux.sv
// tb_mem_resp_demux: directed bench for mem_resp_demux with a queue-based
// reference model and a per-cycle compare process.
// Honours MEM_RESP_DEMUX_ERR_EN the same way the design does.
module tb_mem_resp_demux;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 4;
  localparam int CW         = $clog2(DEPTH+1);

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic                  REQ_VALID;
  logic                  REQ_SRC;
  logic                  REQ_READY;
  logic                  MEM_RESP_VALID;
  logic [DATA_WIDTH-1:0] MEM_RESP_DATA;
  logic                  OUT0_VALID;
  logic [DATA_WIDTH-1:0] OUT0_DATA;
  logic                  OUT1_VALID;
  logic [DATA_WIDTH-1:0] OUT1_DATA;
  logic [CW-1:0]         PENDING;
  logic                  ERR;

  int errorCount = 0;
  int checkCount = 0;
  bit errEnabled;

  mem_resp_demux #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .REQ_VALID     (REQ_VALID),
    .REQ_SRC       (REQ_SRC),
    .REQ_READY     (REQ_READY),
    .MEM_RESP_VALID(MEM_RESP_VALID),
    .MEM_RESP_DATA (MEM_RESP_DATA),
    .OUT0_VALID    (OUT0_VALID),
    .OUT0_DATA     (OUT0_DATA),
    .OUT1_VALID    (OUT1_VALID),
    .OUT1_DATA     (OUT1_DATA),
    .PENDING       (PENDING),
    .ERR           (ERR)
  );

  // Free-running clock, period 10.
  always #5 CLK = ~CLK;

  // Reference model: outstanding sources in arrival order plus the
  // expected registered outputs.
  bit                    modelTags[$];
  bit                    expValid0 = 1'b0;
  bit                    expValid1 = 1'b0;
  logic [DATA_WIDTH-1:0] expData0  = '0;
  logic [DATA_WIDTH-1:0] expData1  = '0;
  bit                    expErr    = 1'b0;

  task automatic modelClear();
    modelTags.delete();
    expValid0 = 1'b0;
    expValid1 = 1'b0;
    expData0  = '0;
    expData1  = '0;
    expErr    = 1'b0;
  endtask

  // Model reacts to reset asynchronously, like the design.
  always @(negedge RESET) modelClear();

  // Model step: inputs are stable at the rising edge.
  always @(posedge CLK) begin
    if (!RESET) begin
      modelClear();
    end else begin
      bit canPush;
      bit tag;
      canPush   = REQ_VALID && (modelTags.size() < DEPTH);
      expValid0 = 1'b0;
      expValid1 = 1'b0;
      if (MEM_RESP_VALID) begin
        if (modelTags.size() != 0) begin
          tag = modelTags.pop_front();
          if (tag) begin
            expValid1 = 1'b1;
            expData1  = MEM_RESP_DATA;
          end else begin
            expValid0 = 1'b1;
            expData0  = MEM_RESP_DATA;
          end
        end else if (errEnabled) begin
          expErr = 1'b1;
        end
      end
      if (canPush) modelTags.push_back(REQ_SRC);
    end
  end

  task automatic checkValue(input string name, input logic [63:0] actual,
                            input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge CLK) begin
    checkValue("cmp OUT0_VALID", 64'(OUT0_VALID), 64'(expValid0));
    checkValue("cmp OUT1_VALID", 64'(OUT1_VALID), 64'(expValid1));
    checkValue("cmp OUT0_DATA",  64'(OUT0_DATA),  64'(expData0));
    checkValue("cmp OUT1_DATA",  64'(OUT1_DATA),  64'(expData1));
    checkValue("cmp PENDING",    64'(PENDING),    64'(modelTags.size()));
    checkValue("cmp REQ_READY",  64'(REQ_READY),  64'(modelTags.size() != DEPTH));
    checkValue("cmp ERR",        64'(ERR),        64'(expErr));
  end

  // Drives one cycle of inputs just after a falling edge and returns at the
  // next falling edge, where the results of that cycle are visible.
  task automatic applyStimulus(input bit reqValid, input bit reqSrc,
                               input bit respValid,
                               input logic [DATA_WIDTH-1:0] respData);
    #1;
    REQ_VALID      = reqValid;
    REQ_SRC        = reqSrc;
    MEM_RESP_VALID = respValid;
    MEM_RESP_DATA  = respData;
    @(negedge CLK);
  endtask

  // Hand-computed literal expectations on the current outputs.
  task automatic checkOutput(input string name, input bit v0, input bit v1,
                             input int pending, input bit ready);
    checkValue({name, " OUT0_VALID"}, 64'(OUT0_VALID), 64'(v0));
    checkValue({name, " OUT1_VALID"}, 64'(OUT1_VALID), 64'(v1));
    checkValue({name, " PENDING"},    64'(PENDING),    64'(pending));
    checkValue({name, " REQ_READY"},  64'(REQ_READY),  64'(ready));
  endtask

  initial begin
`ifdef MEM_RESP_DEMUX_ERR_EN
    errEnabled = 1'b1;
`else
    errEnabled = 1'b0;
`endif
    RESET          = 1'b0;
    REQ_VALID      = 1'b0;
    REQ_SRC        = 1'b0;
    MEM_RESP_VALID = 1'b0;
    MEM_RESP_DATA  = '0;

    // Reset then idle.
    @(negedge CLK);
    @(negedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    checkOutput("reset", 1'b0, 1'b0, 0, 1'b1);
    checkValue("reset OUT0_DATA", 64'(OUT0_DATA), 64'h0);
    checkValue("reset OUT1_DATA", 64'(OUT1_DATA), 64'h0);
    checkValue("reset ERR", 64'(ERR), 64'h0);

    // Ordered steering: I, D, I.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("order pushed", 1'b0, 1'b0, 3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hAAAA0001);
    checkOutput("order r1", 1'b1, 1'b0, 2, 1'b1);
    checkValue("order r1 OUT0_DATA", 64'(OUT0_DATA), 64'hAAAA0001);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hBBBB0002);
    checkOutput("order r2", 1'b0, 1'b1, 1, 1'b1);
    checkValue("order r2 OUT1_DATA", 64'(OUT1_DATA), 64'hBBBB0002);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hCCCC0003);
    checkOutput("order r3", 1'b1, 1'b0, 0, 1'b1);
    checkValue("order r3 OUT0_DATA", 64'(OUT0_DATA), 64'hCCCC0003);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("order idle", 1'b0, 1'b0, 0, 1'b1);
    checkValue("order hold OUT0_DATA", 64'(OUT0_DATA), 64'hCCCC0003);
    checkValue("order hold OUT1_DATA", 64'(OUT1_DATA), 64'hBBBB0002);

    // Full boundary: four D-tags, then push and response together.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("full", 1'b0, 1'b0, 4, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hDDDD0004);
    checkOutput("full push+pop", 1'b0, 1'b1, 3, 1'b1);
    checkValue("full OUT1_DATA", 64'(OUT1_DATA), 64'hDDDD0004);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h1000_0000 + 32'(i));
    checkOutput("full drained", 1'b0, 1'b1, 0, 1'b1);
    checkValue("full last OUT1_DATA", 64'(OUT1_DATA), 64'h10000002);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Wrap-around: push/pop pairs with alternating sources.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(i < 10, 1'(i % 2), 1'b1, 32'h5000_0000 + 32'(i));
      checkValue("wrap PENDING<=1", 64'(PENDING <= 1), 64'h1);
      checkValue("wrap port", 64'({OUT1_VALID, OUT0_VALID}),
                 ((i - 1) % 2 == 1) ? 64'h2 : 64'h1);
    end
    checkOutput("wrap end", 1'b0, 1'b1, 0, 1'b1);

    // Unexpected response.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hEEEE0005);
    checkOutput("unexp", 1'b0, 1'b0, 0, 1'b1);
    checkValue("unexp ERR", 64'(ERR), 64'(errEnabled));
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkValue("unexp ERR sticky", 64'(ERR), 64'(errEnabled));

    // Reset mid-flight.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'(i % 2), 1'b0, '0);
    checkOutput("mid pushed", 1'b0, 1'b0, 3, 1'b1);
    #1 RESET     = 1'b0;
    REQ_VALID    = 1'b0;
    #1;
    checkOutput("mid reset", 1'b0, 1'b0, 0, 1'b1);
    checkValue("mid reset ERR", 64'(ERR), 64'h0);
    @(negedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF0006);
    checkOutput("mid resp", 1'b0, 1'b0, 0, 1'b1);
    checkValue("mid resp ERR", 64'(ERR), 64'(errEnabled));
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_resp_demux.md
# mem_resp_demux

Registered 1-to-2 response demultiplexer between the shared main-memory port and the two caches of the RV32IM pipeline. Each read request granted to memory records its source (instruction cache or data cache) in an in-order tag FIFO. Each memory response pops one tag and is steered, one cycle later, to the matching cache output port. It is the return-path counterpart of the request-side 2-to-1 selection.

## Interface
Parameters:
- DATA_WIDTH, 32: width of a memory response word.
- DEPTH, 4: maximum outstanding requests; power of two, at least 2.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- REQ_VALID  input  1  a memory read request is issued this cycle.
- REQ_SRC  input  1  request source: 0 = I-cache, 1 = D-cache.
- REQ_READY  output  1  tag FIFO can accept a request.
- MEM_RESP_VALID  input  1  memory returns a word this cycle.
- MEM_RESP_DATA  input  DATA_WIDTH  returned word.
- OUT0_VALID  output  1  response for the I-cache.
- OUT0_DATA  output  DATA_WIDTH  I-cache response data.
- OUT1_VALID  output  1  response for the D-cache.
- OUT1_DATA  output  DATA_WIDTH  D-cache response data.
- PENDING  output  $clog2(DEPTH+1)  count of outstanding requests.
- ERR  output  1  sticky flag: response arrived with no outstanding request.

## Operation
- Tag FIFO: DEPTH entries of 1 bit, with a write pointer, a read pointer and a count.
  - Pointers wrap modulo DEPTH.
  - REQ_READY = (count != DEPTH), combinational from registered count only.
- Push: REQ_VALID && REQ_READY writes REQ_SRC at the write pointer, advances the pointer and increments the count.
  - REQ_VALID while REQ_READY = 0 is ignored. The issuer must not do this.
- Pop: MEM_RESP_VALID && count != 0 reads the head tag, advances the read pointer and decrements the count.
- Steering: the popped tag selects the output.
  - Tag 0: next cycle OUT0_VALID = 1 and OUT0_DATA = captured data; OUT1_VALID = 0.
  - Tag 1: the mirror image, on OUT1.
- The inactive port's DATA holds its previous value.
- VALID outputs are single-cycle pulses. No backpressure: caches always accept.
- Simultaneous push and pop:
  - Both occur and the count is unchanged.
  - When count == DEPTH at the edge, the push is blocked because REQ_READY = 0; the pop still occurs. There is no full-bypass.
  - When count == 0, the pop cannot use the same-cycle pushed tag; see Configuration.
- PENDING = count, registered.

## Timing
- Reset (asynchronous, RESET low): pointers and count = 0; OUT0_VALID, OUT1_VALID, ERR = 0; OUT0_DATA, OUT1_DATA = 0; PENDING = 0; REQ_READY = 1.
- Reset asserted mid-operation discards all outstanding tags immediately. A response arriving after reset is treated as unexpected.
- Response latency: exactly 1 cycle from the MEM_RESP_VALID edge to the OUTn_VALID edge.
- Throughput: one push and one pop per cycle sustained.
- Back-to-back responses to alternating sources give alternating OUT0/OUT1 pulses on consecutive cycles.

## Configuration
- MEM_RESP_DEMUX_ERR_EN defined:
  - A response with count == 0 sets ERR the next cycle.
  - ERR stays high until reset.
  - The response is dropped: no OUTn_VALID.
- MEM_RESP_DEMUX_ERR_EN undefined:
  - ERR is tied to 0.
  - The unexpected response is dropped silently.
  - No error register is synthesized.

## Test plan
- Reset then idle: RESET low at t=0, released at cycle 2 -> all outputs 0, REQ_READY = 1, PENDING = 0.
- Ordered steering: push I, D, I; responses 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003 on consecutive cycles -> OUT0 gives AAAA0001, OUT1 gives BBBB0002, OUT0 gives CCCC0003, each one cycle after input; PENDING steps 3, 2, 1, 0.
- Full boundary: push 4 D-tags -> REQ_READY = 0, PENDING = 4.
  - Then push plus response in the same cycle -> push ignored, OUT1_VALID pulses, PENDING = 3, REQ_READY = 1.
- Wrap-around: 10 push/pop pairs alternating sources with pointers crossing DEPTH -> every response lands on the correct port and PENDING never exceeds 1.
- Unexpected response (macro defined): MEM_RESP_VALID with PENDING = 0 -> no OUTn_VALID, ERR = 1 next cycle and sticky; without the macro, ERR stays 0.
- Reset mid-flight: 3 pushes, RESET pulsed low, then one response -> PENDING = 0 immediately, no OUTn_VALID, ERR = 1 only with the macro defined.
